bcd_count_display: RTL and testbench
====================================

Name: bcd_count_display

Overview:
- Downstream consumer of the one-shot tick counter output.
- Accumulates tick events into a NUM_DIGITS-digit decimal BCD count (up or down), with clear and hold.
- Time-multiplexes the count onto a common-anode seven-segment display.
- Sits between the tick generator and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of BCD digits counted and displayed (2..8).
- SCAN_DIV, 16: clk cycles each digit is driven before the scan advances (>=2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  count request from upstream tick counter; level tolerated, rising edge detected internally.
- up_down  input  1  1 = count up, 0 = count down; sampled on the counting edge.
- clear  input  1  synchronous clear of the count.
- hold  input  1  1 = ignore tick edges; count frozen.
- blank_lz  input  1  1 = blank leading zero digits (digit 0 is never blanked).
- count  output  4*NUM_DIGITS  packed BCD count; digit 0 (ones) in bits [3:0].
- carry  output  1  one-cycle pulse on wrap (up: max to 0, down: 0 to max).
- an  output  NUM_DIGITS  digit enables, active low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.

Behaviour:
- Reset (async, while rst=1):
  - count=0, carry=0, tick_q=0, prescaler=0, digit select=0.
  - an = all ones except bit0 low; seg = pattern for 0 (7'b1000000).
- Edge detect:
  - tick_q registers tick every cycle.
  - tick_edge = tick & ~tick_q.
  - A tick held high produces exactly one event.
  - A tick already high when rst deasserts produces one event on the first edge.
- Count update (registered; new value visible after the edge on which tick_edge=1):
  - Priority: clear > hold > tick_edge.
  - clear=1: count=0, carry=0, regardless of tick or hold.
  - hold=1: count unchanged, carry=0; the suppressed edge is lost, not queued.
  - Up: digit 0 increments. A digit at 9 goes to 0 and propagates increment to the next digit; ripple is resolved within the same cycle.
  - Down: a digit at 0 goes to 9 and propagates decrement.
  - Wrap: all digits 9 counting up, or all digits 0 counting down, wraps to 0 / all 9s. carry=1 for exactly the cycle after that edge, else 0.
- Digit validity:
  - Digits never hold A-F under legal operation.
  - Not reachable externally; the scan decoder must still map A-F to all segments off (7'b1111111).
- Scan:
  - prescaler counts 0..SCAN_DIV-1 continuously and is unaffected by hold or clear.
  - At SCAN_DIV-1 it wraps to 0 and digit select advances; NUM_DIGITS-1 wraps to 0.
  - an and seg are registered together from the current select and count, so they are never mismatched by more than zero cycles.
  - Segment map, active low, gfedcba:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking (blank_lz=1):
  - A digit k>0 is blanked (seg=1111111, an still driven) if it and all higher digits are 0.
- Simultaneous events:
  - clear with tick_edge: clear wins, and the edge is consumed (tick_q still updates).
  - up_down changing on the edge cycle: the sampled value applies.
- Reset mid-operation: all state returns to reset values immediately; no partial ripple is retained.

Test Plan:
- Reset, then tick pulsed high for 1 cycle 12 times, up_down=1 -> count=16'h0012, carry never asserted.
- tick held high for 50 cycles after one rising edge -> count increments by exactly 1.
- Preload by counting to 16'h9999, up_down=1, one tick edge -> count=16'h0000, carry=1 for exactly one cycle.
- From 0, up_down=0, one tick edge -> count=16'h9999, carry pulse; second edge -> 16'h9998, no carry.
- hold=1 during 5 tick edges -> count unchanged. clear=1 coincident with tick edge at count 16'h0347 -> count=16'h0000 next cycle.
- SCAN_DIV=4, count=16'h0021, blank_lz=1 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg=1111001, 0100100, 1111111, 1111111. Assert rst mid-scan -> an=1110, seg=1000000 immediately.

Source files
------------

// File: rtl/bcd_count_display.sv
// Decimal BCD event counter driven by tick rising edges, time-multiplexed onto
// a common-anode seven-segment display with optional leading-zero blanking.
module bcd_count_display #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    up_down,
  input  logic                    clear,
  input  logic                    hold,
  input  logic                    blank_lz,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    carry,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic                    tick_q;
  logic                    tick_edge;
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic                    carry_q, carry_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              cur_digit;
  logic                    blank_cur;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  assign tick_edge = tick & ~tick_q;

  // Full decimal ripple resolved combinationally; leftover borrow/carry is the wrap.
  always_comb begin
    logic       prop;
    logic [3:0] dig;
    prop    = 1'b1;
    dig     = 4'd0;
    count_d = count_q;
    carry_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (!hold && tick_edge) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig = count_q[4*i +: 4];
        if (prop) begin
          if (up_down) begin
            if (dig == 4'd9) begin
              count_d[4*i +: 4] = 4'd0;
            end else begin
              count_d[4*i +: 4] = dig + 4'd1;
              prop = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              count_d[4*i +: 4] = 4'd9;
            end else begin
              count_d[4*i +: 4] = dig - 4'd1;
              prop = 1'b0;
            end
          end
        end
      end
      carry_d = prop;
    end
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    sel_d = sel_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      sel_d = (sel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  // Walk from the top digit down so run_zero means "this and every higher digit is 0".
  always_comb begin
    logic run_zero;
    run_zero  = 1'b1;
    cur_digit = 4'd0;
    blank_cur = 1'b0;
    an_d      = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero && (count_q[4*i +: 4] == 4'd0);
      if (sel_q == SEL_W'(i)) begin
        cur_digit = count_q[4*i +: 4];
        blank_cur = blank_lz && run_zero && (i != 0);
        an_d[i]   = 1'b0;
      end
    end
    seg_d = blank_cur ? SEG_BLANK : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q  <= 1'b0;
      count_q <= '0;
      carry_q <= 1'b0;
      pre_q   <= '0;
      sel_q   <= '0;
      an_q    <= AN_RST;
      seg_q   <= SEG_ZERO;
    end else begin
      tick_q  <= tick;
      count_q <= count_d;
      carry_q <= carry_d;
      pre_q   <= pre_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_bcd_count_display.sv
// Bench for bcd_count_display: table vectors plus model-driven sequences, with
// expected count/carry queued at drive time and popped after each clock edge.
module tb_bcd_count_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick, up_down, clear, hold, blank_lz;
  logic [15:0] count;
  logic        carry;
  logic [3:0]  an;
  logic [6:0]  seg;

  bcd_count_display #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .up_down(up_down), .clear(clear),
    .hold(hold), .blank_lz(blank_lz), .count(count), .carry(carry),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        t, ud, c, h;
    logic [15:0] exp_cnt;
    logic        exp_cy;
  } vec_t;

  typedef struct {
    logic [15:0] cnt;
    logic        cy;
    string       name;
  } exp_t;

  vec_t  tbl[20];
  exp_t  sb_q[$];
  int    tests = 0;
  int    failed = 0;
  int    model_val;
  logic  model_tick;
  logic [6:0] seg_exp_blank[4];
  logic [6:0] seg_exp_full[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input logic t, input logic ud, input logic c, input logic h,
                            output logic [15:0] cnt, output logic cy);
    logic edge_seen;
    edge_seen  = t & ~model_tick;
    model_tick = t;
    cy = 1'b0;
    if (c) model_val = 0;
    else if (!h && edge_seen) begin
      if (ud) begin
        if (model_val == 9999) begin model_val = 0; cy = 1'b1; end
        else model_val++;
      end else begin
        if (model_val == 0) begin model_val = 9999; cy = 1'b1; end
        else model_val--;
      end
    end
    cnt = to_bcd(model_val);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic drive_cycle(input logic t, input logic ud, input logic c, input logic h,
                             input logic [15:0] exp_cnt, input logic exp_cy, input string name);
    exp_t e;
    tick = t; up_down = ud; clear = c; hold = h;
    sb_q.push_back('{exp_cnt, exp_cy, name});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("[TB] %s tick=%0b ud=%0b clr=%0b hold=%0b -> count=%04h carry=%0b (exp %04h/%0b)",
             e.name, t, ud, c, h, count, carry, e.cnt, e.cy);
    check({e.name, "_count"}, count, e.cnt);
    check({e.name, "_carry"}, carry, e.cy);
    @(negedge clk);
  endtask

  task automatic mcycle(input logic t, input logic ud, input logic c, input logic h,
                        input string name);
    logic [15:0] ec;
    logic        ey;
    model_step(t, ud, c, h, ec, ey);
    drive_cycle(t, ud, c, h, ec, ey, name);
  endtask

  task automatic pulse(input logic ud, input string name);
    mcycle(1'b1, ud, 1'b0, 1'b0, name);
    mcycle(1'b0, ud, 1'b0, 1'b0, name);
  endtask

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic scan_check(input logic [6:0] exp_tab[4], input string name);
    int idx, prev_idx, run;
    bit seen;
    prev_idx = -1; run = 0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      idx = an_index(an);
      check({name, "_an_valid"}, (idx >= 0), 1);
      if (idx >= 0) check({name, "_seg"}, seg, exp_tab[idx]);
      if (idx == prev_idx) run++;
      else begin
        if (prev_idx >= 0) begin
          check({name, "_order"}, idx, (prev_idx + 1) % 4);
          if (seen) check({name, "_dwell"}, run, 4);
          seen = 1'b1;
        end
        run = 1;
        prev_idx = idx;
      end
    end
    $display("[TB] %s scan window done", name);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mc;
    logic        my;
    bit          found;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h9999, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h9999, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
    seg_exp_blank = '{7'b1111001, 7'b0100100, 7'b1111111, 7'b1111111};
    seg_exp_full  = '{7'b1111001, 7'b0100100, 7'b1000000, 7'b1000000};

    rst = 1'b1; tick = 1'b0; up_down = 1'b1; clear = 1'b0; hold = 1'b0; blank_lz = 1'b0;
    model_val = 0; model_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_count", count, 16'h0000);
    check("reset_carry", carry, 1'b0);
    check("reset_an", an, 4'b1110);
    check("reset_seg", seg, 7'b1000000);
    $display("[TB] reset: count=%04h carry=%0b an=%b seg=%b", count, carry, an, seg);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      model_step(tbl[i].t, tbl[i].ud, tbl[i].c, tbl[i].h, mc, my);
      drive_cycle(tbl[i].t, tbl[i].ud, tbl[i].c, tbl[i].h, tbl[i].exp_cnt, tbl[i].exp_cy,
                  $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 12; i++) pulse(1'b1, "pulse_up");
    check("twelve_pulses", count, 16'h0012);

    mcycle(1'b1, 1'b1, 1'b0, 1'b0, "held_tick");
    for (int i = 0; i < 49; i++) mcycle(1'b1, 1'b1, 1'b0, 1'b0, "held_tick");
    mcycle(1'b0, 1'b1, 1'b0, 1'b0, "held_release");
    check("held_tick_once", count, 16'h0013);

    for (int i = 0; i < 2000 && model_val != 347; i++) pulse(1'b1, "to_347");
    check("reach_0347", count, 16'h0347);
    for (int i = 0; i < 5; i++) begin
      mcycle(1'b1, 1'b1, 1'b0, 1'b1, "hold_edge");
      mcycle(1'b0, 1'b1, 1'b0, 1'b1, "hold_low");
    end
    check("hold_unchanged", count, 16'h0347);
    mcycle(1'b1, 1'b1, 1'b1, 1'b0, "clear_with_edge");
    check("clear_wins", count, 16'h0000);
    mcycle(1'b0, 1'b1, 1'b0, 1'b0, "after_clear");

    mcycle(1'b1, 1'b0, 1'b0, 1'b0, "down_wrap");
    check("down_wrap_val", count, 16'h9999);
    mcycle(1'b0, 1'b0, 1'b0, 1'b0, "down_wrap_low");
    mcycle(1'b1, 1'b0, 1'b0, 1'b0, "down_9998");
    mcycle(1'b0, 1'b0, 1'b0, 1'b0, "down_9998_low");
    pulse(1'b1, "up_9999");
    mcycle(1'b1, 1'b1, 1'b0, 1'b0, "up_wrap");
    check("up_wrap_val", count, 16'h0000);
    mcycle(1'b0, 1'b1, 1'b0, 1'b0, "up_wrap_low");

    rst = 1'b1; tick = 1'b1;
    #1;
    check("rst_tick_hi_count", count, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    model_val = 0; model_tick = 1'b0;
    mcycle(1'b1, 1'b1, 1'b0, 1'b0, "post_rst_edge");
    mcycle(1'b1, 1'b1, 1'b0, 1'b0, "post_rst_held");
    mcycle(1'b0, 1'b1, 1'b0, 1'b0, "post_rst_low");

    for (int i = 0; i < 200 && model_val != 21; i++) pulse(1'b1, "to_21");
    check("reach_0021", count, 16'h0021);
    blank_lz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    scan_check(seg_exp_blank, "scan_blank");
    blank_lz = 1'b0;
    @(negedge clk);
    @(negedge clk);
    scan_check(seg_exp_full, "scan_full");

    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1011) found = 1'b1;
    end
    check("scan_reach_digit2", found, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midscan_rst_an", an, 4'b1110);
    check("midscan_rst_seg", seg, 7'b1000000);
    check("midscan_rst_count", count, 16'h0000);
    $display("[TB] mid-scan reset: an=%b seg=%b count=%04h", an, seg, count);
    @(negedge clk);
    rst = 1'b0;
    model_val = 0; model_tick = 1'b0;
    mcycle(1'b0, 1'b1, 1'b0, 1'b0, "after_midscan_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
